// File: rtl/key_pkg.sv
// Shared types and defaults for the push-button conditioning stage.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int DEBOUNCE_CYCLES_SIM = 4;

  // Debounced level is "pressed" until the release has been confirmed.
  function automatic logic is_level_state(input key_state_t s);
    return (s == PRESSED) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Bundle of raw board inputs and conditioned outputs for key_conditioner.
interface key_conditioner_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_raw;
  logic              sw_pause_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_pulse;
  logic              any_pulse;
  logic              pause;

  modport master (
    output key_raw, sw_pause_raw,
    input  key_level, key_pulse, any_pulse, pause
  );

  modport slave (
    input  key_raw, sw_pause_raw,
    output key_level, key_pulse, any_pulse, pause
  );
endinterface

// File: rtl/key_debounce.sv
// One key: polarity fix, two-flop synchronizer, debounce FSM and press pulse.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  input  logic mask_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic       pressed_s;
  logic       meta_q;
  logic       sync_q;
  key_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       pulse_q, pulse_d;
  logic       level_q;

  assign pressed_s = ACTIVE_LOW ? ~raw_i : raw_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= RELEASED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      meta_q  <= pressed_s;
      sync_q  <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= is_level_state(state_d);
    end
  end

  // mask_i is the pause value that becomes visible in the same cycle as the pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (sync_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_MAX) begin
          state_d = PRESSED;
          pulse_d = ~mask_i;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      RELEASE_WAIT: begin
        if (sync_q) begin
          state_d = PRESSED;
        end else if (cnt_q >= CNT_MAX) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions raw board buttons and the pause switch into clean levels and
// single-cycle press pulses for the downstream LED cells.
module key_conditioner
  import key_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  key_conditioner_if.slave bus
);

  logic              pause_meta_q;
  logic              pause_q;
  logic [N_KEYS-1:0] level_s;
  logic [N_KEYS-1:0] pulse_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      pause_meta_q <= 1'b0;
      pause_q      <= 1'b0;
    end else begin
      pause_meta_q <= bus.sw_pause_raw;
      pause_q      <= pause_meta_q;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (KEY_ACTIVE_LOW)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (bus.key_raw[g]),
      .mask_i  (pause_meta_q),
      .level_o (level_s[g]),
      .pulse_o (pulse_s[g])
    );
  end

  // Pulses are masked at their source, so the register outputs are already clean.
  assign bus.key_level = level_s;
  assign bus.key_pulse = pulse_s;
  assign bus.any_pulse = |pulse_s;
  assign bus.pause     = pause_q;

endmodule
